// File: rtl/riscv_lsu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : riscv_lsu                                                    |
// | Description : Single-outstanding load/store unit with lane steering,       |
// |               sign/zero extension, misalignment and bus-timeout reporting. |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module riscv_lsu #(
  parameter int          WORD_LENGTH    = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_in_valid,
  output logic                   o_in_ready,
  input  logic                   i_is_store,
  input  logic [2:0]             i_mem_funct3,
  input  logic [WORD_LENGTH-1:0] i_addr,
  input  logic [WORD_LENGTH-1:0] i_store_data,
  input  logic [4:0]             i_rd,
  output logic                   o_dmem_req,
  output logic                   o_dmem_we,
  output logic [WORD_LENGTH-1:0] o_dmem_addr,
  output logic [3:0]             o_dmem_wstrb,
  output logic [WORD_LENGTH-1:0] o_dmem_wdata,
  input  logic                   i_dmem_gnt,
  input  logic                   i_dmem_rvalid,
  input  logic [WORD_LENGTH-1:0] i_dmem_rdata,
  output logic                   o_wb_valid,
  output logic                   o_wb_we,
  output logic [4:0]             o_wb_rd,
  output logic [WORD_LENGTH-1:0] o_wb_data,
  output logic                   o_misalign_exc,
  output logic                   o_bus_err,
  output logic [WORD_LENGTH-1:0] o_exc_addr
);

  localparam logic [2:0]  c_F3_B    = 3'b000;
  localparam logic [2:0]  c_F3_H    = 3'b001;
  localparam logic [2:0]  c_F3_W    = 3'b010;
  localparam logic [2:0]  c_F3_BU   = 3'b100;
  localparam logic [2:0]  c_F3_HU   = 3'b101;
  localparam logic [31:0] c_TIMEOUT = TIMEOUT_CYCLES;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_DONE = 3'd3,
    S_EXC  = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic                   r_is_store;
  logic [2:0]             r_funct3;
  logic [WORD_LENGTH-1:0] r_addr;
  logic [WORD_LENGTH-1:0] r_sdata;
  logic [4:0]             r_rd;
  logic [31:0]            r_cnt;
  logic [WORD_LENGTH-1:0] r_ld_data;

  logic                   w_misalign;
  logic [3:0]             w_wstrb;
  logic [WORD_LENGTH-1:0] w_wdata;
  logic [WORD_LENGTH-1:0] w_shift;
  logic [WORD_LENGTH-1:0] w_ld_ext;

  // Reserved encodings and stores with unsigned widths fold into the misaligned path.
  always_comb begin
    w_misalign = 1'b1;
    case (i_mem_funct3)
      c_F3_B:  w_misalign = 1'b0;
      c_F3_H:  w_misalign = i_addr[0];
      c_F3_W:  w_misalign = |i_addr[1:0];
      c_F3_BU: w_misalign = i_is_store;
      c_F3_HU: w_misalign = i_is_store | i_addr[0];
      default: w_misalign = 1'b1;
    endcase
  end

  always_comb begin
    w_wstrb = 4'b0000;
    w_wdata = '0;
    case (r_funct3[1:0])
      2'b00: begin
        w_wstrb = 4'b0001 << r_addr[1:0];
        w_wdata = {(WORD_LENGTH/8){r_sdata[7:0]}};
      end
      2'b01: begin
        w_wstrb = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {(WORD_LENGTH/16){r_sdata[15:0]}};
      end
      default: begin
        w_wstrb = 4'b1111;
        w_wdata = r_sdata;
      end
    endcase
  end

  always_comb begin
    w_shift  = i_dmem_rdata >> {r_addr[1:0], 3'b000};
    w_ld_ext = i_dmem_rdata;
    case (r_funct3)
      c_F3_B:  w_ld_ext = {{(WORD_LENGTH-8){w_shift[7]}}, w_shift[7:0]};
      c_F3_H:  w_ld_ext = {{(WORD_LENGTH-16){w_shift[15]}}, w_shift[15:0]};
      c_F3_BU: w_ld_ext = {{(WORD_LENGTH-8){1'b0}}, w_shift[7:0]};
      c_F3_HU: w_ld_ext = {{(WORD_LENGTH-16){1'b0}}, w_shift[15:0]};
      default: w_ld_ext = i_dmem_rdata;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (i_in_valid) w_next = w_misalign ? S_EXC : S_REQ;
      S_REQ:  if (i_dmem_gnt) w_next = r_is_store ? S_DONE : S_WAIT;
      S_WAIT: begin
        if (i_dmem_rvalid)                                    w_next = S_DONE;
        else if ((c_TIMEOUT != 32'd0) && (r_cnt == c_TIMEOUT - 32'd1)) w_next = S_ERR;
      end
      S_DONE, S_EXC, S_ERR: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_is_store <= 1'b0;
      r_funct3   <= 3'b000;
      r_addr     <= '0;
      r_sdata    <= '0;
      r_rd       <= 5'd0;
      r_cnt      <= 32'd0;
      r_ld_data  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && i_in_valid) begin
        r_is_store <= i_is_store;
        r_funct3   <= i_mem_funct3;
        r_addr     <= i_addr;
        r_sdata    <= i_store_data;
        r_rd       <= i_rd;
      end
      r_cnt <= (r_state == S_WAIT) ? r_cnt + 32'd1 : 32'd0;
      if (r_state == S_WAIT && i_dmem_rvalid) r_ld_data <= w_ld_ext;
    end
  end

  always_comb begin
    o_in_ready     = (r_state == S_IDLE);
    o_dmem_req     = 1'b0;
    o_dmem_we      = 1'b0;
    o_dmem_addr    = '0;
    o_dmem_wstrb   = 4'b0000;
    o_dmem_wdata   = '0;
    o_wb_valid     = 1'b0;
    o_wb_we        = 1'b0;
    o_wb_rd        = 5'd0;
    o_wb_data      = '0;
    o_misalign_exc = 1'b0;
    o_bus_err      = 1'b0;
    o_exc_addr     = '0;
    case (r_state)
      S_REQ: begin
        o_dmem_req  = 1'b1;
        o_dmem_we   = r_is_store;
        o_dmem_addr = {r_addr[WORD_LENGTH-1:2], 2'b00};
        if (r_is_store) begin
          o_dmem_wstrb = w_wstrb;
          o_dmem_wdata = w_wdata;
        end
      end
      S_DONE: begin
        o_wb_valid = 1'b1;
        o_wb_rd    = r_rd;
        if (!r_is_store) begin
          o_wb_we   = (r_rd != 5'd0);
          o_wb_data = r_ld_data;
        end
      end
      S_EXC: begin
        o_misalign_exc = 1'b1;
        o_exc_addr     = r_addr;
      end
      S_ERR: begin
        o_bus_err  = 1'b1;
        o_exc_addr = r_addr;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
- Load/store unit; sits directly downstream of the execute-stage ALU and consumes its alu_out as the effective address.
- Accepts one memory operation at a time over a valid/ready handshake and drives a request/grant/rvalid data-memory port.
- Performs byte/halfword lane steering, store strobes, load sign/zero extension and misalignment detection.
- Returns a one-cycle writeback pulse toward the register file.

Parameters:
WORD_LENGTH, 32, datapath width; behaviour below is defined for 32 only.
TIMEOUT_CYCLES, 255, maximum WAIT cycles before bus_err; 0 disables the timeout.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  operation offered
in_ready  out  1  LSU can accept; high only in IDLE
is_store  in  1  1=store, 0=load
mem_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
addr  in  WORD_LENGTH  effective address (ALU alu_out)
store_data  in  WORD_LENGTH  rs2 value
rd  in  5  load destination register
dmem_req  out  1  memory request
dmem_we  out  1  write enable
dmem_addr  out  WORD_LENGTH  word-aligned address (addr[1:0]=0)
dmem_wstrb  out  4  byte strobes
dmem_wdata  out  WORD_LENGTH  lane-shifted store data
dmem_gnt  in  1  request accepted
dmem_rvalid  in  1  read data valid
dmem_rdata  in  WORD_LENGTH  read word
wb_valid  out  1  one-cycle completion pulse
wb_we  out  1  register write enable (load and rd!=0)
wb_rd  out  5  destination
wb_data  out  WORD_LENGTH  extended load result
misalign_exc  out  1  one-cycle misaligned-access pulse
bus_err  out  1  one-cycle timeout pulse
exc_addr  out  WORD_LENGTH  faulting address (valid with either exception pulse)

Behaviour:
- Reset: state IDLE; every output 0 except in_ready=1; timeout counter 0.
- Accept: in_valid&&in_ready at a clock edge latches is_store, funct3, addr, store_data and rd.
- Misalignment: H/HU with addr[0]!=0, or W with addr[1:0]!=0.
  - Evaluated at accept; goes to EXC.
  - No memory request is issued.
- States:
  - IDLE: in_ready=1. Accept -> REQ, or -> EXC if misaligned.
  - REQ: dmem_req=1 with stable address/we/strb/wdata until dmem_gnt.
    - Store + gnt -> DONE.
    - Load + gnt -> WAIT.
  - WAIT: dmem_req=0; counter increments each cycle.
    - dmem_rvalid -> DONE, latching the extended data.
    - Counter reaching TIMEOUT_CYCLES (when nonzero) -> ERR.
  - DONE: wb_valid=1 for exactly one cycle -> IDLE.
  - EXC: misalign_exc=1 for one cycle -> IDLE.
  - ERR: bus_err=1 for one cycle -> IDLE.
- dmem_rvalid is sampled only in WAIT; rvalid in any other state is ignored.
- Stores:
  - SB: wstrb=1<<addr[1:0], wdata=byte replicated x4.
  - SH: wstrb=0011 or 1100, wdata=half replicated x2.
  - SW: wstrb=1111.
  - dmem_we=1 only for stores.
- Loads: the byte/half is selected by addr[1:0] from dmem_rdata. B/H sign-extend, BU/HU zero-extend, W passes through.
- Store completion: wb_valid=1, wb_we=0, wb_data=0.
- Load to rd=0: full memory access, then wb_valid=1, wb_we=0.
- Reserved funct3 (011,110,111) and store with BU/HU: treated as misaligned (EXC), exc_addr=addr.
- Minimum latency:
  - Load: accept at cycle 0, req and gnt at 1, rvalid at 2, wb_valid at 3.
  - Store: gnt at 1, wb_valid at 2.
- Reset mid-operation: returns to IDLE the next edge, drops dmem_req, suppresses pending pulses; a later rvalid is ignored.
- No new operation is accepted while not IDLE (single outstanding).

Test Plan:
- Reset, then SW addr=0x100 data=0xDEADBEEF, gnt on first REQ cycle -> dmem_addr=0x100, wstrb=1111, wdata=0xDEADBEEF; wb_valid at cycle 2, wb_we=0.
- SB addr=0x103 data=0x000000A5 -> wstrb=1000, wdata=0xA5A5A5A5. Then LB addr=0x103 with rdata=0xA5000000 -> wb_data=0xFFFFFFA5; LBU gives 0x000000A5.
- LH addr=0x102 with rdata=0x80010000, rd=7 -> wb_data=0xFFFF8001, wb_we=1, wb_rd=7. Same access with rd=0 -> wb_we=0.
- LW addr=0x101 -> no dmem_req ever; misalign_exc pulse at cycle 1, exc_addr=0x101; in_ready back at cycle 2.
- Load with gnt delayed 3 cycles: REQ holds all outputs stable. TIMEOUT_CYCLES=4 with rvalid never asserted -> bus_err pulse, then IDLE.
- Assert rst during WAIT, then rvalid one cycle after reset releases -> no wb_valid; dmem_req=0; in_ready=1.
